// File: rtl/uart_tx.sv
// 8N1 serial transmitter for the memory-mapped serial port.
// Bytes written by the memory stage queue in a small FIFO and leave LSB first.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [BW-1:0]   baud_cnt, baud_d;
  logic [2:0]      bit_idx, bit_d;
  logic [7:0]      shift, shift_d;
  logic            tx_d;
  logic            pop;
  logic            push;
  logic            fifo_empty;
  logic            bit_end;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  assign tx_ready   = (count < CW'(FIFO_DEPTH));
  assign push       = wr_en & tx_ready;
  assign fifo_empty = (count == '0);
  assign bit_end    = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  // Storage is not reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register; tx is a flop so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shift    <= shift_d;
      tx       <= tx_d;
    end
  end

  // Next state; STOP reloads straight into START so queued bytes leave gap-free.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift[7:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_cnt + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Outputs; the line value is computed from the upcoming state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    tx_busy = (state != IDLE) | (count != '0);
  end

endmodule
